// File: rtl/crc_bus_host_if.sv
// Register-port bus between the CRC host (master) and the CRC32 peripheral (slave).
interface crc_bus_host_if;
    logic [5:0]  per_address;
    logic [31:0] per_wdata;
    logic [1:0]  per_write_n;
    logic [1:0]  per_read_n;
    logic [31:0] per_rdata;
    logic        per_ready;

    modport master (
        output per_address,
        output per_wdata,
        output per_write_n,
        output per_read_n,
        input  per_rdata,
        input  per_ready
    );

    modport slave (
        input  per_address,
        input  per_wdata,
        input  per_write_n,
        input  per_read_n,
        output per_rdata,
        output per_ready
    );
endinterface

// File: rtl/crc_bus_host.sv
// CRC32 peripheral bus initiator: programs the peripheral, streams frame bytes
// into its FIFO with bounded bursts, then closes the frame and reads the CRC.
module crc_bus_host #(
    parameter int unsigned MAX_BURST = 8,
    parameter int unsigned DONE_WAIT = 4,
    parameter int unsigned TIMEOUT   = 255
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [31:0]    cfg_poly,
    input  logic [2:0]     cfg_mode,
    input  logic [7:0]     s_data,
    input  logic           s_valid,
    input  logic           s_last,
    output logic           s_ready,
    output logic [31:0]    crc_out,
    output logic           crc_valid,
    output logic           busy,
    output logic           timeout_err,
    crc_bus_host_if.master bus
);

    localparam int unsigned BURST_W = 4;
    localparam int unsigned WAIT_W  = $clog2(TIMEOUT + 1);
    localparam int unsigned DONE_W  = $clog2(DONE_WAIT + 1);

    localparam logic [BURST_W-1:0] BURST_MAX = BURST_W'(MAX_BURST);
    localparam logic [WAIT_W-1:0]  WAIT_LAST = WAIT_W'(TIMEOUT - 1);
    localparam logic [DONE_W-1:0]  DONE_LAST = DONE_W'(DONE_WAIT - 1);

    localparam logic [5:0] ADDR_EN     = 6'h00;
    localparam logic [5:0] ADDR_CFG    = 6'h04;
    localparam logic [5:0] ADDR_DATA   = 6'h08;
    localparam logic [5:0] ADDR_RESULT = 6'h0C;
    localparam logic [5:0] ADDR_POLY   = 6'h10;

    localparam logic [1:0] OP_BYTE = 2'b00;
    localparam logic [1:0] OP_WORD = 2'b10;
    localparam logic [1:0] OP_NONE = 2'b11;

    typedef enum logic [3:0] {
        IDLE,
        WR_POLY,
        WR_CFG,
        WR_EN,
        GET,
        WR_DATA,
        DRAIN,
        WR_DIS,
        DWAIT,
        RD_RES
    } state_t;

    state_t              state;
    logic [2:0]          mode_q;
    logic                last_q;
    logic                abort_q;
    logic [BURST_W-1:0]  burst_cnt;
    logic [BURST_W-1:0]  burst_inc;
    logic [WAIT_W-1:0]   wait_cnt;
    logic [DONE_W-1:0]   done_cnt;

    // Saturating next value of the DATA-writes-since-drain counter.
    always_comb begin
        burst_inc = (burst_cnt == BURST_MAX) ? burst_cnt : burst_cnt + BURST_W'(1);
    end

    // Sequencer: bus outputs are registered alongside the state they belong to.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state           <= IDLE;
            mode_q          <= 3'b000;
            last_q          <= 1'b0;
            abort_q         <= 1'b0;
            burst_cnt       <= '0;
            wait_cnt        <= '0;
            done_cnt        <= '0;
            s_ready         <= 1'b0;
            crc_out         <= 32'h0;
            crc_valid       <= 1'b0;
            busy            <= 1'b0;
            timeout_err     <= 1'b0;
            bus.per_address <= 6'h00;
            bus.per_wdata   <= 32'h0;
            bus.per_write_n <= OP_NONE;
            bus.per_read_n  <= OP_NONE;
        end else begin
            bus.per_write_n <= OP_NONE;
            bus.per_read_n  <= OP_NONE;
            crc_valid       <= 1'b0;
            case (state)
                IDLE: begin
                    if (s_valid) begin
                        mode_q          <= cfg_mode;
                        timeout_err     <= 1'b0;
                        abort_q         <= 1'b0;
                        last_q          <= 1'b0;
                        burst_cnt       <= '0;
                        busy            <= 1'b1;
                        bus.per_address <= ADDR_POLY;
                        bus.per_wdata   <= cfg_poly;
                        bus.per_write_n <= OP_WORD;
                        state           <= WR_POLY;
                    end
                end
                WR_POLY: begin
                    bus.per_address <= ADDR_CFG;
                    bus.per_wdata   <= 32'(mode_q);
                    bus.per_write_n <= OP_BYTE;
                    state           <= WR_CFG;
                end
                WR_CFG: begin
                    bus.per_address <= ADDR_EN;
                    bus.per_wdata   <= 32'h1;
                    bus.per_write_n <= OP_BYTE;
                    state           <= WR_EN;
                end
                WR_EN: begin
                    s_ready <= 1'b1;
                    state   <= GET;
                end
                GET: begin
                    if (s_valid) begin
                        s_ready         <= 1'b0;
                        last_q          <= s_last;
                        bus.per_address <= ADDR_DATA;
                        bus.per_wdata   <= 32'(s_data);
                        bus.per_write_n <= OP_BYTE;
                        state           <= WR_DATA;
                    end
                end
                WR_DATA: begin
                    burst_cnt <= burst_inc;
                    if (last_q || (burst_inc == BURST_MAX)) begin
                        bus.per_address <= ADDR_RESULT;
                        bus.per_read_n  <= OP_WORD;
                        wait_cnt        <= '0;
                        state           <= DRAIN;
                    end else begin
                        s_ready <= 1'b1;
                        state   <= GET;
                    end
                end
                DRAIN: begin
                    if (bus.per_ready) begin
                        burst_cnt <= '0;
                        if (last_q) begin
                            bus.per_address <= ADDR_EN;
                            bus.per_wdata   <= 32'h0;
                            bus.per_write_n <= OP_BYTE;
                            state           <= WR_DIS;
                        end else begin
                            s_ready <= 1'b1;
                            state   <= GET;
                        end
                    end else if (wait_cnt == WAIT_LAST) begin
                        timeout_err     <= 1'b1;
                        abort_q         <= 1'b1;
                        bus.per_address <= ADDR_EN;
                        bus.per_wdata   <= 32'h0;
                        bus.per_write_n <= OP_BYTE;
                        state           <= WR_DIS;
                    end else begin
                        wait_cnt       <= wait_cnt + WAIT_W'(1);
                        bus.per_read_n <= OP_WORD;
                    end
                end
                WR_DIS: begin
                    done_cnt <= '0;
                    state    <= DWAIT;
                end
                DWAIT: begin
                    if (done_cnt == DONE_LAST) begin
                        if (abort_q) begin
                            busy  <= 1'b0;
                            state <= IDLE;
                        end else begin
                            bus.per_address <= ADDR_RESULT;
                            bus.per_read_n  <= OP_WORD;
                            wait_cnt        <= '0;
                            state           <= RD_RES;
                        end
                    end else begin
                        done_cnt <= done_cnt + DONE_W'(1);
                    end
                end
                RD_RES: begin
                    if (bus.per_ready) begin
                        crc_out   <= bus.per_rdata;
                        crc_valid <= 1'b1;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end else if (wait_cnt == WAIT_LAST) begin
                        timeout_err <= 1'b1;
                        busy        <= 1'b0;
                        state       <= IDLE;
                    end else begin
                        wait_cnt       <= wait_cnt + WAIT_W'(1);
                        bus.per_read_n <= OP_WORD;
                    end
                end
                default: begin
                    s_ready <= 1'b0;
                    busy    <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_crc_bus_host.sv
// Directed bench for crc_bus_host with a behavioural CRC32 peripheral model.
module tb_crc_bus_host;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] cfg_poly = 32'h04C11DB7;
    logic [2:0]  cfg_mode = 3'b111;
    logic [7:0]  s_data = 8'h00;
    logic        s_valid = 1'b0;
    logic        s_last = 1'b0;
    logic        s_ready;
    logic [31:0] crc_out;
    logic        crc_valid;
    logic        busy;
    logic        timeout_err;

    crc_bus_host_if bus ();

    crc_bus_host dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cfg_poly    (cfg_poly),
        .cfg_mode    (cfg_mode),
        .s_data      (s_data),
        .s_valid     (s_valid),
        .s_last      (s_last),
        .s_ready     (s_ready),
        .crc_out     (crc_out),
        .crc_valid   (crc_valid),
        .busy        (busy),
        .timeout_err (timeout_err),
        .bus         (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Knobs driven only by the stimulus process.
    int stall_req    = 0;
    bit block_result = 1'b0;

    // Peripheral model state, written only by the monitor.
    logic [31:0] m_poly = 32'h0;
    logic [2:0]  m_mode = 3'b000;
    logic [31:0] m_crc = 32'h0;
    logic        m_en = 1'b0;
    int          rd_run = 0;
    int          m_data_writes = 0;
    int          m_drains = 0;
    int          drain_at [64];
    int          since_drain = 0;
    int          max_burst = 0;
    int          m_res_cycles = 0;
    int          m_valids = 0;
    int          m_long = 0;
    int          m_both = 0;
    logic        prev_valid = 1'b0;
    int          trace [$];

    logic [7:0]  frame_buf [32];

    function automatic logic [31:0] crc_step(input logic [31:0] c_in, input logic [7:0] b,
                                             input logic [31:0] poly, input logic refl);
        logic [31:0] c;
        logic [31:0] rp;
        c = c_in;
        for (int i = 0; i < 32; i++) rp[i] = poly[31-i];
        if (refl) begin
            c = c ^ {24'h0, b};
            for (int i = 0; i < 8; i++) c = c[0] ? ((c >> 1) ^ rp) : (c >> 1);
        end else begin
            c = c ^ {b, 24'h0};
            for (int i = 0; i < 8; i++) c = c[31] ? ((c << 1) ^ poly) : (c << 1);
        end
        return c;
    endfunction

    function automatic logic [31:0] frame_crc(input int len, input logic [31:0] poly,
                                              input logic [2:0] mode);
        logic [31:0] c;
        c = mode[2] ? 32'hFFFF_FFFF : 32'h0;
        for (int i = 0; i < len; i++) c = crc_step(c, frame_buf[i], poly, mode[0]);
        return mode[1] ? ~c : c;
    endfunction

    assign bus.per_ready = (bus.per_read_n == 2'b10) && (rd_run >= stall_req) &&
                           !(block_result && !m_en);
    assign bus.per_rdata = m_mode[1] ? ~m_crc : m_crc;

    // Peripheral model and bus monitor.
    always @(posedge clk) begin
        if (!rst_n) begin
            m_en   <= 1'b0;
            rd_run <= 0;
        end else begin
            if (bus.per_write_n != 2'b11 && bus.per_read_n != 2'b11) m_both <= m_both + 1;
            if (bus.per_write_n != 2'b11) begin
                case (bus.per_address)
                    6'h10: m_poly <= bus.per_wdata;
                    6'h04: m_mode <= bus.per_wdata[2:0];
                    6'h00: begin
                        m_en <= bus.per_wdata[0];
                        if (bus.per_wdata[0]) m_crc <= m_mode[2] ? 32'hFFFF_FFFF : 32'h0;
                    end
                    6'h08: begin
                        m_crc <= crc_step(m_crc, bus.per_wdata[7:0], m_poly, m_mode[0]);
                        m_data_writes <= m_data_writes + 1;
                        since_drain <= since_drain + 1;
                        if (since_drain + 1 > max_burst) max_burst <= since_drain + 1;
                    end
                    default: ;
                endcase
            end
            if (bus.per_read_n == 2'b10) begin
                if (!m_en) m_res_cycles <= m_res_cycles + 1;
                if (bus.per_ready) begin
                    rd_run <= 0;
                    if (m_en) begin
                        drain_at[m_drains] <= m_data_writes;
                        m_drains <= m_drains + 1;
                        since_drain <= 0;
                    end
                end else begin
                    rd_run <= rd_run + 1;
                end
            end else begin
                rd_run <= 0;
            end
            if (busy) begin
                if (bus.per_write_n != 2'b11) trace.push_back(32'h100 | 32'(bus.per_address));
                else if (bus.per_read_n != 2'b11) trace.push_back(32'h200 | 32'(bus.per_address));
                else trace.push_back(0);
            end
        end
        if (crc_valid) m_valids <= m_valids + 1;
        if (crc_valid && prev_valid) m_long <= m_long + 1;
        prev_valid <= crc_valid;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic send_frame(input int len);
        int waited;
        for (int i = 0; i < len; i++) begin
            @(negedge clk);
            s_data  = frame_buf[i];
            s_valid = 1'b1;
            s_last  = (i == len - 1);
            waited  = 0;
            while (!s_ready && waited < 2000) begin
                @(negedge clk);
                waited++;
            end
            check_eq("s_ready_hs", 32'(s_ready), 32'h1);
            if (!s_ready) break;
            @(posedge clk);
        end
        @(negedge clk);
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic wait_done();
        int waited;
        waited = 0;
        while (busy && waited < 2000) begin
            @(negedge clk);
            waited++;
        end
        repeat (2) @(negedge clk);
        check_eq("frame_done", 32'(busy), 32'h0);
    endtask

    initial begin
        int base_w, base_d, base_v, base_r, base_t, bad, k;
        logic [31:0] exp_crc, saved;
        int exp6 [12];

        // Reset state
        repeat (3) @(negedge clk);
        check_eq("rst_write_n", 32'(bus.per_write_n), 32'h3);
        check_eq("rst_read_n", 32'(bus.per_read_n), 32'h3);
        check_eq("rst_busy_ready", 32'({busy, s_ready, crc_valid, timeout_err}), 32'h0);
        check_eq("rst_crc_addr", crc_out | 32'(bus.per_address), 32'h0);
        rst_n = 1'b1;
        @(negedge clk);

        // 1: CRC-32 check string
        cfg_mode = 3'b111;
        cfg_poly = 32'h04C11DB7;
        for (int i = 0; i < 9; i++) frame_buf[i] = 8'h31 + 8'(i);
        base_w = m_data_writes; base_d = m_drains; base_v = m_valids;
        send_frame(9);
        wait_done();
        check_eq("t1_crc", crc_out, 32'hCBF43926);
        check_eq("t1_valid_cnt", 32'(m_valids - base_v), 32'd1);
        check_eq("t1_data_writes", 32'(m_data_writes - base_w), 32'd9);
        check_eq("t1_drain1_at", 32'(drain_at[base_d] - base_w), 32'd8);
        check_eq("t1_drain2_at", 32'(drain_at[base_d + 1] - base_w), 32'd9);

        // 2: 20-byte frame, bursts bounded by the FIFO depth
        for (int i = 0; i < 20; i++) frame_buf[i] = 8'(i * 7 + 3);
        exp_crc = frame_crc(20, 32'h04C11DB7, 3'b111);
        base_w = m_data_writes; base_d = m_drains; base_v = m_valids;
        send_frame(20);
        wait_done();
        check_eq("t2_crc", crc_out, exp_crc);
        check_eq("t2_data_writes", 32'(m_data_writes - base_w), 32'd20);
        check_eq("t2_drain_cnt", 32'(m_drains - base_d), 32'd3);
        check_eq("t2_drain1_at", 32'(drain_at[base_d] - base_w), 32'd8);
        check_eq("t2_drain2_at", 32'(drain_at[base_d + 1] - base_w), 32'd16);
        check_eq("t2_drain3_at", 32'(drain_at[base_d + 2] - base_w), 32'd20);

        // 4: result read never answered
        saved = crc_out;
        block_result = 1'b1;
        frame_buf[0] = 8'h61;
        base_v = m_valids; base_r = m_res_cycles;
        send_frame(1);
        wait_done();
        check_eq("t4_timeout_err", 32'(timeout_err), 32'h1);
        check_eq("t4_no_valid", 32'(m_valids - base_v), 32'd0);
        check_eq("t4_read_cycles", 32'(m_res_cycles - base_r), 32'd255);
        check_eq("t4_crc_held", crc_out, saved);
        block_result = 1'b0;

        // 3: drain read stalled for 10 cycles; also clears the sticky error
        stall_req = 10;
        base_v = m_valids;
        fork
            begin
                send_frame(1);
                wait_done();
            end
            begin
                k = 0;
                while (bus.per_read_n != 2'b10 && k < 200) begin
                    @(negedge clk);
                    k++;
                end
                check_eq("t3_drain_seen", 32'(bus.per_read_n), 32'h2);
                check_eq("t3_terr_cleared", 32'(timeout_err), 32'h0);
                bad = 0;
                for (int i = 0; i < 10; i++) begin
                    if (bus.per_address != 6'h0C || bus.per_read_n != 2'b10 ||
                        s_ready || bus.per_ready) bad++;
                    @(negedge clk);
                end
                check_eq("t3_drain_hold", 32'(bad), 32'h0);
            end
        join
        stall_req = 0;
        check_eq("t3_crc", crc_out, 32'hE8B7BE43);
        check_eq("t3_valid_cnt", 32'(m_valids - base_v), 32'd1);

        // 5: reset while a DATA write is on the bus
        @(negedge clk);
        s_data = 8'h55; s_last = 1'b0; s_valid = 1'b1;
        k = 0;
        while (!(bus.per_write_n != 2'b11 && bus.per_address == 6'h08) && k < 200) begin
            @(negedge clk);
            k++;
        end
        check_eq("t5_in_wr_data", 32'(bus.per_address), 32'h08);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check_eq("t5_write_n", 32'(bus.per_write_n), 32'h3);
        check_eq("t5_read_n", 32'(bus.per_read_n), 32'h3);
        check_eq("t5_busy_ready", 32'({busy, s_ready}), 32'h0);
        check_eq("t5_crc_cleared", crc_out, 32'h0);
        @(negedge clk);
        s_valid = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);

        // 6: single zero byte, mode 0; full bus trace
        cfg_mode = 3'b000;
        frame_buf[0] = 8'h00;
        exp6 = '{32'h110, 32'h104, 32'h100, 0, 32'h108, 32'h20C, 32'h100, 0, 0, 0, 0, 32'h20C};
        base_t = trace.size(); base_v = m_valids;
        send_frame(1);
        wait_done();
        check_eq("t6_trace_len", 32'(trace.size() - base_t), 32'd12);
        if (trace.size() >= base_t + 12) begin
            for (int i = 0; i < 12; i++) check_eq($sformatf("t6_trace%0d", i), 32'(trace[base_t + i]), 32'(exp6[i]));
        end
        check_eq("t6_crc", crc_out, 32'h0);
        check_eq("t6_valid_cnt", 32'(m_valids - base_v), 32'd1);

        // Whole-run bus invariants
        check_eq("rw_overlap", 32'(m_both), 32'h0);
        check_eq("valid_pulse_1cyc", 32'(m_long), 32'h0);
        check_eq("max_burst", 32'(max_burst), 32'd8);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
